// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

  localparam int unsigned MULDIV_LAT_MIN = 2;
  localparam int unsigned MULDIV_LAT_MAX = 16;
  localparam logic [4:0]  REG_X0         = 5'd0;

  // True when a used source register names a real (non-x0) destination.
  function automatic logic reg_match(input logic       use_reg,
                                     input logic [4:0] src,
                                     input logic [4:0] dst);
    return use_reg && (src == dst) && (dst != REG_X0);
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_seq.sv
// MUL/DIV sequencer: holds the front end for MULDIV_LAT cycles, then flags
// the result valid for one cycle.
module md_seq
  import hazard_pkg::*;
#(
  parameter int unsigned MULDIV_LAT = 4,
  parameter int unsigned CNT_W      = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic md_stall,
  output logic md_busy,
  output logic md_done
);

  if ((MULDIV_LAT < MULDIV_LAT_MIN) || (MULDIV_LAT > MULDIV_LAT_MAX) ||
      ((64'd1 << CNT_W) < 64'(MULDIV_LAT))) begin : g_bad_param
    $error("md_seq: MULDIV_LAT/CNT_W out of range");
  end

  md_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The IDLE cycle that accepts the op already stalls, so BUSY runs for
  // MULDIV_LAT-1 cycles (counter MULDIV_LAT-2 down to 0).
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    md_stall  = 1'b0;
    md_busy   = 1'b0;
    md_done   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          md_stall  = 1'b1;
          state_nxt = BUSY;
          cnt_nxt   = CNT_W'(MULDIV_LAT - 2);
        end
      end
      BUSY: begin
        md_stall = 1'b1;
        md_busy  = 1'b1;
        if (cnt == '0) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      DONE: begin
        md_busy   = 1'b1;
        md_done   = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: MUL/DIV hold, load-use stall, branch flush.
// Optional HAZARD_PERF_EN adds saturating stall-cycle counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MULDIV_LAT = 4,
  parameter int unsigned CNT_W      = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_use_rs1_i,
  input  logic        id_use_rs2_i,
  input  logic        id_branch_taken_i,
  input  logic        ex_memread_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_muldiv_i,
  output logic        pc_write_o,
  output logic        ifid_write_o,
  output logic        ifid_flush_o,
  output logic        idex_write_o,
  output logic        idex_bubble_o,
  output logic        exmem_bubble_o,
  output logic        md_done_o,
  output logic        md_busy_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_lu_stall_o,
  output logic [31:0] perf_md_stall_o
`endif
);

  logic md_stall;
  logic lu_hit;
  logic lu_stall;
  logic br_flush;

  md_seq #(
    .MULDIV_LAT (MULDIV_LAT),
    .CNT_W      (CNT_W)
  ) u_md_seq (
    .clk      (clk_i),
    .rst      (rst_i),
    .start    (ex_muldiv_i),
    .md_stall (md_stall),
    .md_busy  (md_busy_o),
    .md_done  (md_done_o)
  );

  // Priority: MUL/DIV hold > load-use > branch flush.
  always_comb begin
    lu_hit   = ex_memread_i &&
               (reg_match(id_use_rs1_i, id_rs1_i, ex_rd_i) ||
                reg_match(id_use_rs2_i, id_rs2_i, ex_rd_i));
    lu_stall = !md_stall && lu_hit;
    br_flush = !md_stall && !lu_hit && id_branch_taken_i;
  end

  always_comb begin
    pc_write_o     = 1'b1;
    ifid_write_o   = 1'b1;
    ifid_flush_o   = 1'b0;
    idex_write_o   = 1'b1;
    idex_bubble_o  = 1'b0;
    exmem_bubble_o = 1'b0;
    if (md_stall) begin
      pc_write_o     = 1'b0;
      ifid_write_o   = 1'b0;
      idex_write_o   = 1'b0;
      exmem_bubble_o = 1'b1;
    end else if (lu_stall) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
    end else if (br_flush) begin
      ifid_flush_o = 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] lu_cnt;
  logic [31:0] md_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lu_cnt <= '0;
      md_cnt <= '0;
    end else begin
      if (lu_stall && (lu_cnt != '1)) begin
        lu_cnt <= lu_cnt + 32'd1;
      end
      if (md_stall && (md_cnt != '1)) begin
        md_cnt <= md_cnt + 32'd1;
      end
    end
  end

  assign perf_lu_stall_o = lu_cnt;
  assign perf_md_stall_o = md_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: cycle-index reference model plus
// directed vectors with literal expectations.
module tb_hazard_ctrl;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, id_branch_taken, ex_memread, ex_muldiv;
  logic        pc_write, ifid_write, ifid_flush, idex_write, idex_bubble;
  logic        exmem_bubble, md_done, md_busy;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_lu, perf_md;
`endif

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MULDIV_LAT(LAT), .CNT_W(4)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .id_rs1_i          (id_rs1),
    .id_rs2_i          (id_rs2),
    .id_use_rs1_i      (id_use_rs1),
    .id_use_rs2_i      (id_use_rs2),
    .id_branch_taken_i (id_branch_taken),
    .ex_memread_i      (ex_memread),
    .ex_rd_i           (ex_rd),
    .ex_muldiv_i       (ex_muldiv),
    .pc_write_o        (pc_write),
    .ifid_write_o      (ifid_write),
    .ifid_flush_o      (ifid_flush),
    .idex_write_o      (idex_write),
    .idex_bubble_o     (idex_bubble),
    .exmem_bubble_o    (exmem_bubble),
    .md_done_o         (md_done),
    .md_busy_o         (md_busy)
`ifdef HAZARD_PERF_EN
    ,
    .perf_lu_stall_o   (perf_lu),
    .perf_md_stall_o   (perf_md)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: k = cycles elapsed in the current MUL/DIV op (0 = none).
  // Stall covers the accepting cycle plus k=1..LAT-1; k=LAT is the done cycle.
  int k;
  int m_lu_cnt, m_md_cnt;

  typedef struct packed {
    logic stall, lu, flush, busy, done;
  } exp_t;

  function automatic exp_t model(input int kk);
    exp_t e;
    logic dep;
    e.stall = (kk == 0 && ex_muldiv) || (kk >= 1 && kk < LAT);
    e.busy  = (kk >= 1);
    e.done  = (kk == LAT);
    dep = (id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd);
    e.lu    = !e.stall && ex_memread && (ex_rd != 5'd0) && dep;
    e.flush = !e.stall && !e.lu && id_branch_taken;
    return e;
  endfunction

  always @(posedge clk or posedge rst) begin
    exp_t e;
    if (rst) begin
      k        <= 0;
      m_lu_cnt <= 0;
      m_md_cnt <= 0;
    end else begin
      e = model(k);
      if (e.lu) m_lu_cnt <= m_lu_cnt + 1;
      if (e.stall) m_md_cnt <= m_md_cnt + 1;
      if (k == 0) k <= ex_muldiv ? 1 : 0;
      else if (k == LAT) k <= 0;
      else k <= k + 1;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    e = model(k);
    chk("m_pc_write",     32'(pc_write),     32'(!e.stall && !e.lu));
    chk("m_ifid_write",   32'(ifid_write),   32'(!e.stall && !e.lu));
    chk("m_ifid_flush",   32'(ifid_flush),   32'(e.flush));
    chk("m_idex_write",   32'(idex_write),   32'(!e.stall));
    chk("m_idex_bubble",  32'(idex_bubble),  32'(e.lu));
    chk("m_exmem_bubble", 32'(exmem_bubble), 32'(e.stall));
    chk("m_md_done",      32'(md_done),      32'(e.done));
    chk("m_md_busy",      32'(md_busy),      32'(e.busy));
`ifdef HAZARD_PERF_EN
    chk("m_perf_lu", perf_lu, 32'(m_lu_cnt));
    chk("m_perf_md", perf_md, 32'(m_md_cnt));
`endif
  end

  task automatic clr();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_branch_taken = 1'b0;
    ex_memread = 1'b0; ex_muldiv = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_use(input logic [4:0] r);
    ex_memread = 1'b1; ex_rd = r; id_rs1 = r; id_use_rs1 = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    clr();
    #1;
    chk("rst_async_pc_write", 32'(pc_write), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pc_write",   32'(pc_write),   32'd1);
    chk("rst_ifid_write", 32'(ifid_write), 32'd1);
    chk("rst_idex_write", 32'(idex_write), 32'd1);
    chk("rst_flush",      32'(ifid_flush), 32'd0);
    chk("rst_bubbles",    32'({idex_bubble, exmem_bubble}), 32'd0);
    chk("rst_md",         32'({md_done, md_busy}), 32'd0);
    step();
    rst = 1'b0;

    // Load-use on rs1, then normal next cycle.
    load_use(5'd5);
    @(negedge clk);
    chk("lu_pc_write",   32'(pc_write),    32'd0);
    chk("lu_ifid_write", 32'(ifid_write),  32'd0);
    chk("lu_bubble",     32'(idex_bubble), 32'd1);
    chk("lu_idex_write", 32'(idex_write),  32'd1);
    step();
    ex_memread = 1'b0;
    @(negedge clk);
    chk("lu_after_pc_write", 32'(pc_write),    32'd1);
    chk("lu_after_bubble",   32'(idex_bubble), 32'd0);
    step();

    // x0 destination never stalls.
    load_use(5'd0);
    @(negedge clk);
    chk("x0_pc_write", 32'(pc_write), 32'd1);
    step();
    clr();

    // Unused rs2 match, then used rs2 match.
    ex_memread = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_rs1 = 5'd3; id_use_rs1 = 1'b1;
    @(negedge clk);
    chk("rs2_unused_pc_write", 32'(pc_write), 32'd1);
    step();
    id_use_rs2 = 1'b1;
    @(negedge clk);
    chk("rs2_used_bubble", 32'(idex_bubble), 32'd1);
    step();
    clr();

    // Branch flush; load-use dependent branch stalls first, flushes on retry.
    id_branch_taken = 1'b1;
    @(negedge clk);
    chk("br_flush",    32'(ifid_flush), 32'd1);
    chk("br_pc_write", 32'(pc_write),   32'd1);
    step();
    load_use(5'd9);
    @(negedge clk);
    chk("br_lu_flush",  32'(ifid_flush),  32'd0);
    chk("br_lu_bubble", 32'(idex_bubble), 32'd1);
    step();
    ex_memread = 1'b0;
    @(negedge clk);
    chk("br_retry_flush", 32'(ifid_flush), 32'd1);
    step();
    clr();

    // Back-to-back MUL/DIV with the op held; dropped on cycle 11.
    ex_muldiv = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      if (c == 11) ex_muldiv = 1'b0;
      @(negedge clk);
      chk($sformatf("md_stall_c%0d", c), 32'(!pc_write && exmem_bubble),
          32'((c >= 1 && c <= 4) || (c >= 6 && c <= 9)));
      chk($sformatf("md_done_c%0d", c), 32'(md_done), 32'(c == 5 || c == 10));
      chk($sformatf("md_busy_c%0d", c), 32'(md_busy),
          32'((c >= 2 && c <= 5) || (c >= 7 && c <= 10)));
      step();
    end

    // Priority: hazards during BUSY are masked; branch alone flushes in DONE.
    ex_muldiv = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      if (c == 2) begin
        load_use(5'd4);
        id_branch_taken = 1'b1;
      end
      if (c == 5) begin
        clr();
        id_branch_taken = 1'b1;
      end
      if (c == 6) clr();
      @(negedge clk);
      if (c == 2) begin
        chk("pri_busy_flush",  32'(ifid_flush),   32'd0);
        chk("pri_busy_bubble", 32'(idex_bubble),  32'd0);
        chk("pri_busy_exmem",  32'(exmem_bubble), 32'd1);
        chk("pri_busy_pc",     32'(pc_write),     32'd0);
      end
      if (c == 5) begin
        chk("pri_done_done",  32'(md_done),    32'd1);
        chk("pri_done_flush", 32'(ifid_flush), 32'd1);
      end
      if (c == 6) chk("pri_idle_busy", 32'(md_busy), 32'd0);
      step();
    end

    // Reset in the second BUSY cycle aborts the op asynchronously.
    ex_muldiv = 1'b1;
    @(negedge clk);
    step();
    @(negedge clk);
    step();
    #1;
    ex_muldiv = 1'b0;
    rst = 1'b1;
    #1;
    chk("rmid_busy",  32'(md_busy),      32'd0);
    chk("rmid_pc",    32'(pc_write),     32'd1);
    chk("rmid_exmem", 32'(exmem_bubble), 32'd0);
    step();
    step();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("rmid_no_done", 32'(md_done), 32'd0);
      step();
    end

`ifdef HAZARD_PERF_EN
    for (int n = 0; n < 3; n++) begin
      load_use(5'(n + 1));
      step();
      clr();
      step();
    end
    ex_muldiv = 1'b1;
    step();
    ex_muldiv = 1'b0;
    repeat (LAT + 1) step();
    @(negedge clk);
    chk("perf_lu_lit", perf_lu, 32'd3);
    chk("perf_md_lit", perf_md, 32'd4);
`endif

    step();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
